// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per RUN beat.
// Define MIXCOL_INV_EN to honour in_inv and build the inverse-matrix datapath.
module mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int unsigned N      = (COLS_PER_CYCLE == 0) ? 1 : 4 / COLS_PER_CYCLE;
    localparam int unsigned BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(N - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [127:0]        st;
    logic [127:0]        st_next;
    logic [BEAT_W-1:0]   beat;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

`ifdef MIXCOL_INV_EN
    logic inv_q;

    // Each byte's x2/x4/x8 multiples are shared across the 09/0b/0d/0e products.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        {a[0], a[1], a[2], a[3]} = c;
        for (int unsigned i = 0; i < 4; i++) begin
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    // Only the COLS_PER_CYCLE columns addressed by beat pass through the matrix logic.
    always_comb begin
        int unsigned idx;
        logic [31:0] col;
        st_next = st;
        idx     = 0;
        col     = '0;
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
            idx = 32'(beat) * COLS_PER_CYCLE + j;
            col = st[127 - 32*idx -: 32];
`ifdef MIXCOL_INV_EN
            st_next[127 - 32*idx -: 32] = inv_q ? inv_col(col) : fwd_col(col);
`else
            st_next[127 - 32*idx -: 32] = fwd_col(col);
`endif
        end
    end

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign data_out = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            st        <= '0;
            beat      <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= data_in;
                        beat  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef MIXCOL_INV_EN
                        inv_q <= in_inv;
`endif
                    end
                end
                RUN: begin
                    st <= st_next;
                    if (beat == LAST) begin
                        beat      <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Output and input handshakes share this edge: reload with no bubble.
                        if (in_valid) begin
                            st    <= data_in;
                            beat  <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
`ifdef MIXCOL_INV_EN
                            inv_q <= in_inv;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
